// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-port writeback arbiter with pending-write scoreboard (optional WB_BYPASS_EN)
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [AW-1:0]   a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [AW-1:0]   b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  input  logic            mark_valid,
  input  logic [AW-1:0]   mark_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            mark_busy,
  output logic            byp_valid,
  output logic [XLEN-1:0] byp_data
);

  localparam int NREG = 1 << AW;

  // Round-robin pointer: 0 favours A, 1 favours B on the next contended cycle.
  logic            rr_b;
  logic            grant_a;
  logic            grant_b;
  logic [AW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  // Grant selection: an uncontested requester always wins, contention uses the pointer.
  always_comb begin
    grant_a  = a_valid && (!b_valid || !rr_b);
    grant_b  = b_valid && (!a_valid || rr_b);
    win_rd   = grant_b ? b_rd : a_rd;
    win_data = grant_b ? b_data : a_data;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // Pointer flips only when both sides competed, so neither waits more than one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_b <= 1'b0;
    end else if (a_valid && b_valid) begin
      rr_b <= ~rr_b;
    end
  end

  // Registered write port; x0 writes are loaded but never strobed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else if (grant_a || grant_b) begin
      rf_we    <= (win_rd != '0);
      rf_rd    <= win_rd;
      rf_wdata <= win_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  // Scoreboard update: clear on commit, then set on reservation so a same-index set wins.
  always_comb begin
    pending_nxt = pending;
    if (rf_we) begin
      pending_nxt[rf_rd] = 1'b0;
    end
    if (mark_valid && (mark_rd != '0)) begin
      pending_nxt[mark_rd] = 1'b1;
    end
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  assign rs2_busy  = pending[rs2];
  assign mark_busy = pending[mark_rd];

`ifdef WB_BYPASS_EN
  // A commit in flight to rs1 can be forwarded, so rs1 is not reported busy then.
  assign byp_valid = rf_we && (rf_rd == rs1) && (rs1 != '0);
  assign byp_data  = rf_wdata;
  assign rs1_busy  = pending[rs1] && !byp_valid;
`else
  assign byp_valid = 1'b0;
  assign byp_data  = '0;
  assign rs1_busy  = pending[rs1];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard-driven self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_rd, b_rd, rf_rd, mark_rd, rs1, rs2;
  logic [31:0] a_data, b_data, rf_wdata, byp_data;
  logic        rf_we, mark_valid, rs1_busy, rs2_busy, mark_busy, byp_valid;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic m_ptr_b = 1'b0;

  regfile_wb_arbiter #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .mark_valid(mark_valid), .mark_rd(mark_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .mark_busy(mark_busy),
    .byp_valid(byp_valid), .byp_data(byp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset;
    reset = 1'b1;
    a_valid = 0; b_valid = 0; a_rd = 0; b_rd = 0; a_data = 0; b_data = 0;
    mark_valid = 0; mark_rd = 0; rs1 = 0; rs2 = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    checks++; if (rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rf_rd got=%0d exp=0", rf_rd); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_wdata got=%h exp=0", rf_wdata); end
    checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got a=%b b=%b exp 0 0", a_ready, b_ready); end
    checks++; if (byp_valid !== 1'b0) begin errors++; $display("FAIL reset_byp_valid got=%b exp=0", byp_valid); end
    for (int i = 0; i < 32; i++) begin
      rs1 = i[4:0]; rs2 = 5'(31 - i);
      #0.1;
      checks++;
      if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
        errors++; $display("FAIL reset_busy idx=%0d got rs1=%b rs2=%b exp 0 0", i, rs1_busy, rs2_busy);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mark_write;
    wr_t e;
    mark_valid = 1; mark_rd = 5; rs1 = 5; rs2 = 5;
    @(posedge clk); #1;
    mark_valid = 0;
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL mark_rs1_busy got=%b exp=1", rs1_busy); end
    a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL mark_a_ready got a=%b b=%b exp 1 0", a_ready, b_ready); end
    exp_q.push_back('{we: 1'b1, rd: 5'd5, data: 32'hDEADBEEF});
    @(posedge clk); #1;
    a_valid = 0;
    if (exp_q.size() == 0) begin checks++; errors++; $display("FAIL mark_queue got=empty exp=entry"); end
    else begin
      e = exp_q.pop_front();
      checks++; if (rf_we !== e.we || rf_rd !== e.rd || rf_wdata !== e.data) begin
        errors++; $display("FAIL mark_write got we=%b rd=%0d d=%h exp we=%b rd=%0d d=%h", rf_we, rf_rd, rf_wdata, e.we, e.rd, e.data);
      end
    end
    checks++; if (rs2_busy !== 1'b1) begin errors++; $display("FAIL mark_pending_before_commit got=%b exp=1", rs2_busy); end
`ifdef WB_BYPASS_EN
    checks++; if (rs1_busy !== 1'b0 || byp_valid !== 1'b1) begin errors++; $display("FAIL mark_bypass got busy=%b byp=%b exp 0 1", rs1_busy, byp_valid); end
`else
    checks++; if (rs1_busy !== 1'b1 || byp_valid !== 1'b0) begin errors++; $display("FAIL mark_nobypass got busy=%b byp=%b exp 1 0", rs1_busy, byp_valid); end
`endif
    @(posedge clk); #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mark_we_one_cycle got=%b exp=0", rf_we); end
    checks++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin errors++; $display("FAIL mark_cleared got rs1=%b rs2=%b exp 0 0", rs1_busy, rs2_busy); end
  endtask

  task automatic test_contention;
    logic [4:0] a_list[2];
    logic [4:0] b_list[2];
    logic [4:0] seq[4];
    int ai, bi;
    logic ga, gb;
    wr_t e;
    a_list = '{5'd1, 5'd2}; b_list = '{5'd3, 5'd4}; seq = '{5'd1, 5'd3, 5'd2, 5'd4};
    ai = 0; bi = 0;
    for (int c = 0; c < 4; c++) begin
      a_valid = (ai < 2); a_rd = (ai < 2) ? a_list[ai] : 5'd0; a_data = 32'hC0DE_0000 | {27'd0, a_rd};
      b_valid = (bi < 2); b_rd = (bi < 2) ? b_list[bi] : 5'd0; b_data = 32'hB00B_0000 | {27'd0, b_rd};
      @(negedge clk);
      ga = a_valid && (!b_valid || !m_ptr_b);
      gb = b_valid && (!a_valid || m_ptr_b);
      checks++; if (a_ready !== ga || b_ready !== gb) begin errors++; $display("FAIL cont_grant cyc=%0d got a=%b b=%b exp a=%b b=%b", c, a_ready, b_ready, ga, gb); end
      checks++; if (a_ready && b_ready) begin errors++; $display("FAIL cont_both_ready cyc=%0d got 1 1 exp one-hot", c); end
      if (a_valid && b_valid) m_ptr_b = ~m_ptr_b;
      if (ga) exp_q.push_back('{we: (a_rd != 0), rd: a_rd, data: a_data});
      else    exp_q.push_back('{we: (b_rd != 0), rd: b_rd, data: b_data});
      @(posedge clk); #1;
      if (ga) ai++;
      if (gb) bi++;
      if (exp_q.size() == 0) begin checks++; errors++; $display("FAIL cont_queue got=empty exp=entry"); end
      else begin
        e = exp_q.pop_front();
        checks++; if (rf_we !== e.we || rf_rd !== e.rd || rf_wdata !== e.data) begin
          errors++; $display("FAIL cont_write cyc=%0d got we=%b rd=%0d d=%h exp we=%b rd=%0d d=%h", c, rf_we, rf_rd, rf_wdata, e.we, e.rd, e.data);
        end
      end
      checks++; if (rf_rd !== seq[c]) begin errors++; $display("FAIL cont_order cyc=%0d got rd=%0d exp rd=%0d", c, rf_rd, seq[c]); end
    end
    a_valid = 0; b_valid = 0;
    @(posedge clk); #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL cont_idle_we got=%b exp=0", rf_we); end
  endtask

  task automatic test_rd_zero;
    wr_t e;
    mark_valid = 1; mark_rd = 6;
    @(posedge clk); #1;
    mark_valid = 0;
    b_valid = 1; b_rd = 0; b_data = 32'h1234; rs1 = 6; rs2 = 0;
    @(negedge clk);
    checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL rd0_ready got a=%b b=%b exp 0 1", a_ready, b_ready); end
    exp_q.push_back('{we: 1'b0, rd: 5'd0, data: 32'h1234});
    @(posedge clk); #1;
    b_valid = 0;
    e = exp_q.pop_front();
    checks++; if (rf_we !== e.we || rf_rd !== e.rd || rf_wdata !== e.data) begin
      errors++; $display("FAIL rd0_write got we=%b rd=%0d d=%h exp we=%b rd=%0d d=%h", rf_we, rf_rd, rf_wdata, e.we, e.rd, e.data);
    end
    checks++; if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin errors++; $display("FAIL rd0_scoreboard got x6=%b x0=%b exp 1 0", rs1_busy, rs2_busy); end
  endtask

  task automatic test_set_wins;
    wr_t e;
    mark_valid = 1; mark_rd = 7; rs2 = 7;
    @(posedge clk); #1;
    mark_valid = 0;
    a_valid = 1; a_rd = 7; a_data = 32'h0707_0707;
    @(negedge clk);
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL setwin_ready got=%b exp=1", a_ready); end
    exp_q.push_back('{we: 1'b1, rd: 5'd7, data: 32'h0707_0707});
    @(posedge clk); #1;
    a_valid = 0;
    e = exp_q.pop_front();
    checks++; if (rf_we !== e.we || rf_rd !== e.rd || rf_wdata !== e.data) begin
      errors++; $display("FAIL setwin_write got we=%b rd=%0d d=%h exp we=%b rd=%0d d=%h", rf_we, rf_rd, rf_wdata, e.we, e.rd, e.data);
    end
    mark_valid = 1; mark_rd = 7;
    #1;
    checks++; if (mark_busy !== 1'b1) begin errors++; $display("FAIL setwin_mark_busy got=%b exp=1", mark_busy); end
    @(posedge clk); #1;
    mark_valid = 0;
    checks++; if (rs2_busy !== 1'b1) begin errors++; $display("FAIL setwin_pending got=%b exp=1", rs2_busy); end
  endtask

  task automatic test_reset_mid;
    mark_valid = 1; mark_rd = 9;
    @(posedge clk); #1;
    mark_valid = 0;
    a_valid = 1; a_rd = 9; a_data = 32'hA5A5A5A5; rs1 = 9;
    @(posedge clk); #1;
    a_valid = 0;
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd9) begin errors++; $display("FAIL rstmid_write got we=%b rd=%0d exp 1 9", rf_we, rf_rd); end
`ifdef WB_BYPASS_EN
    checks++; if (byp_valid !== 1'b1 || byp_data !== 32'hA5A5A5A5 || rs1_busy !== 1'b0) begin
      errors++; $display("FAIL bypass_hit got v=%b d=%h busy=%b exp 1 a5a5a5a5 0", byp_valid, byp_data, rs1_busy);
    end
`else
    checks++; if (byp_valid !== 1'b0 || byp_data !== 32'd0 || rs1_busy !== 1'b1) begin
      errors++; $display("FAIL bypass_off got v=%b d=%h busy=%b exp 0 0 1", byp_valid, byp_data, rs1_busy);
    end
`endif
    #2;
    reset = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0) begin
      errors++; $display("FAIL rstmid_out got we=%b rd=%0d d=%h exp 0 0 0", rf_we, rf_rd, rf_wdata);
    end
    for (int i = 0; i < 32; i++) begin
      rs1 = i[4:0]; rs2 = i[4:0];
      #0.1;
      checks++;
      if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
        errors++; $display("FAIL rstmid_busy idx=%0d got rs1=%b rs2=%b exp 0 0", i, rs1_busy, rs2_busy);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rstmid_after got=%b exp=0", rf_we); end
  endtask

  initial begin
    test_reset();
    test_mark_write();
    test_contention();
    test_rd_zero();
    test_set_wins();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
